barrier_multi: RTL and testbench
================================

Name: barrier_multi

Overview:
- Ring-attached barrier unit supporting NGROUPS independent barrier groups, each with a programmable participant count.
- Lets disjoint core subsets synchronise concurrently.
- A local core enters a barrier by selecting a group. The unit waits for the Token, appends itself behind any train, sends one Barrier slot tagged with the group ID, and then waits.
- Completion is signalled to the local core. A watchdog raises barrierTimeout if completion does not arrive within TIMEOUT cycles.

Parameters:
- NGROUPS, 4, number of barrier groups (power of 2, 2..16)
- GW, 2, group ID width = log2(NGROUPS)
- CW, 5, per-group arrival counter and target width
- DEFAULT_TARGET, 12, participant count loaded into every group at reset
- TIMEOUT, 65535, waitBarrier cycle limit (16-bit)
- NULL_T / TOKEN_T / BARRIER_T, 7 / 1 / 13, slot type encodings

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- selBarrier  in  1  local core requests barrier; held until done or barrierTimeout
- barrierId  in  GW  group requested; sampled in idle when selBarrier rises
- setTarget  in  1  one-cycle write of a group participant count
- targetGroup  in  GW  group addressed by setTarget
- targetIn  in  CW  new participant count
- whichCore  in  4  local core number
- msgrWaiting, lockerWaiting  in  1 each  other ring clients contending for the Token
- RingIn  in  32  ring data
- SlotTypeIn  in  4  ring slot type
- SrcDestIn  in  4  ring source/destination
- done  out  1  barrier complete for the local core (combinational pulse)
- barrierTimeout  out  1  one-cycle pulse: watchdog expired
- barrierWaiting  out  1  high in waitToken
- barrierDriveRing  out  1  unit drives the ring this cycle
- barrierRingOut  out  32  ring data out
- barrierSlotTypeOut  out  4  slot type out
- barrierSrcDestOut  out  4  src/dest out

Behaviour:
- Reset (reset=0, asynchronous):
  - state=idle; all count[g]=0; all target[g]=DEFAULT_TARGET; myGroup=0; wdog=0; burstLength=0.
  - done=0, barrierTimeout=0, barrierDriveRing=0.
- Arrival event:
  - arrive = SlotTypeIn==BARRIER_T; arrival group ag = RingIn[GW-1:0].
  - Every arrival updates count[ag] in every state: if count[ag]==eff(target[ag])-1 then count[ag]<=0 and complete[ag]=1 this cycle; otherwise count[ag]<=count[ag]+1.
  - eff(t) = t, or 1 when t==0.
  - Counters of other groups are untouched.
- FSM states and transitions:
  - idle: on selBarrier, latch myGroup<=barrierId, go to waitToken.
  - waitToken: on SlotTypeIn==TOKEN_T & ~msgrWaiting & ~lockerWaiting:
    - RingIn[7:0]==0 → send.
    - Otherwise burstLength<=RingIn[7:0] → waitN.
  - waitN: burstLength decrements each cycle; at burstLength==1 → send.
  - send: one cycle; clear wdog → waitBarrier.
  - waitBarrier:
    - complete[myGroup] → idle.
    - Otherwise, if wdog==TIMEOUT → pulse barrierTimeout → idle. count[myGroup] is NOT cleared.
    - Otherwise wdog+1.
- Outputs:
  - done = selBarrier & state==waitBarrier & complete[myGroup].
  - barrierDriveRing = (waitToken & Token) | send | (arrive & SrcDestIn==whichCore).
  - barrierSlotTypeOut: NULL_T when the unit's own Barrier slot returns; BARRIER_T in send; else SlotTypeIn.
  - barrierSrcDestOut = whichCore in send, else SrcDestIn.
  - barrierRingOut: RingIn+1 on waitToken & Token (joins train); {zero, myGroup} in send; else RingIn.
- Own-slot removal: a returning own slot still counts as an arrival in the same cycle it is nulled.
- setTarget rules:
  - Accepted only when count[targetGroup]==0 and NOT (arrive & ag==targetGroup) in the same cycle; otherwise the write is silently dropped.
  - Takes effect on the next cycle.
- Boundary cases:
  - target=1: own arrival alone completes the group.
  - Arrival for a group other than myGroup never asserts done.
  - selBarrier dropping mid-operation does not abort the FSM. A complete while selBarrier=0 returns to idle with done=0.
  - Counter arithmetic is modulo 2^CW; the target comparison prevents overflow for target ≤ 2^CW-1.

Test Plan:
- Reset then setTarget g1=3; core 2 requests g1; inject Token RingIn=0 → drive cycle with RingIn 1, send cycle Type=13 Src=2 Data=1. Inject two foreign g1 arrivals plus own return → done on third arrival, own slot nulled (Type 7), count[1]=0.
- Token arrives with RingIn[7:0]=3 → RingOut=4, waitN for 3 cycles, then send.
- Interleaved g0 and g1 arrivals (g0 target 12, g1 target 2): g1 completes after 2 g1 arrivals; count[0] unaffected.
- No arrivals after send, TIMEOUT=20 → barrierTimeout pulse 21 cycles after send; state idle; count[myGroup] retains own arrival.
- setTarget g2 while count[2]=1 → ignored; after wrap, setTarget g2=0 → group completes on every single arrival.
- Assert reset mid-waitN → outputs immediately 0; targets return to 12.

Source files
------------

// File: rtl/barrier_multi_if.sv
// ---------------------------------------------------------------------------
// barrier_multi_if
// Bundles the core-side request signals and the ring slot signals of the
// barrier_multi unit.
//   master : drives requests and the incoming ring slot (core + ring upstream)
//   slave  : the barrier unit itself
// Signals:
//   selBarrier/barrierId           barrier request and requested group
//   setTarget/targetGroup/targetIn participant-count write port
//   whichCore                      local core number (own source tag)
//   msgrWaiting/lockerWaiting      other clients contending for the Token
//   RingIn/SlotTypeIn/SrcDestIn    incoming ring slot
//   done/barrierTimeout            completion / watchdog pulses to the core
//   barrierWaiting                 unit is waiting for the Token
//   barrierDriveRing + barrier*Out outgoing ring slot
// ---------------------------------------------------------------------------
interface barrier_multi_if #(
   parameter int GW = 2,
   parameter int CW = 5
);
   logic          selBarrier;
   logic [GW-1:0] barrierId;
   logic          setTarget;
   logic [GW-1:0] targetGroup;
   logic [CW-1:0] targetIn;
   logic [3:0]    whichCore;
   logic          msgrWaiting;
   logic          lockerWaiting;
   logic [31:0]   RingIn;
   logic [3:0]    SlotTypeIn;
   logic [3:0]    SrcDestIn;
   logic          done;
   logic          barrierTimeout;
   logic          barrierWaiting;
   logic          barrierDriveRing;
   logic [31:0]   barrierRingOut;
   logic [3:0]    barrierSlotTypeOut;
   logic [3:0]    barrierSrcDestOut;

   modport master (
      output selBarrier, barrierId, setTarget, targetGroup, targetIn,
             whichCore, msgrWaiting, lockerWaiting, RingIn, SlotTypeIn, SrcDestIn,
      input  done, barrierTimeout, barrierWaiting, barrierDriveRing,
             barrierRingOut, barrierSlotTypeOut, barrierSrcDestOut
   );

   modport slave (
      input  selBarrier, barrierId, setTarget, targetGroup, targetIn,
             whichCore, msgrWaiting, lockerWaiting, RingIn, SlotTypeIn, SrcDestIn,
      output done, barrierTimeout, barrierWaiting, barrierDriveRing,
             barrierRingOut, barrierSlotTypeOut, barrierSrcDestOut
   );
endinterface

// File: rtl/barrier_multi.sv
// ---------------------------------------------------------------------------
// barrier_multi
// Ring-attached barrier unit with NGROUPS independent barrier groups. Each
// group keeps an arrival counter and a programmable participant count. The
// local core enters a barrier on a group: the unit grabs the Token, joins
// the train, emits one Barrier slot tagged with the group ID and waits for
// the group to complete (or for the watchdog to expire).
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   bus    : barrier_multi_if.slave (core request + ring in/out, see interface)
// ---------------------------------------------------------------------------
module barrier_multi #(
   parameter int          NGROUPS        = 4,
   parameter int          GW             = 2,
   parameter int          CW             = 5,
   parameter int          DEFAULT_TARGET = 12,
   parameter int          TIMEOUT        = 65535,
   parameter logic [3:0]  NULL_T         = 4'd7,
   parameter logic [3:0]  TOKEN_T        = 4'd1,
   parameter logic [3:0]  BARRIER_T      = 4'd13
) (
   input  logic         clock,
   input  logic         reset,
   barrier_multi_if.slave bus
);

   localparam logic [15:0]   TIMEOUT_W  = TIMEOUT[15:0];
   localparam logic [CW-1:0] DEF_TARGET = CW'(DEFAULT_TARGET);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TOKEN,
      S_WAIT_N,
      S_SEND,
      S_WAIT_BARRIER
   } state_t;

   state_t        state_q;
   logic [GW-1:0] my_group_q;
   logic [15:0]   wdog_q;
   logic [7:0]    burst_len_q;

   logic               arrive;
   logic [GW-1:0]      arr_group;
   logic               token_ok;
   logic               own_return;
   logic [NGROUPS-1:0] complete;
   logic               my_complete;

   assign arrive     = (bus.SlotTypeIn == BARRIER_T);
   assign arr_group  = bus.RingIn[GW-1:0];
   // The Token is only ours when no other ring client is contending for it.
   assign token_ok   = (bus.SlotTypeIn == TOKEN_T) && !bus.msgrWaiting && !bus.lockerWaiting;
   assign own_return = arrive && (bus.SrcDestIn == bus.whichCore);

   // -----------------------------------------------------------------------
   // Per-group arrival counters and participant targets. Arrivals are
   // counted in every FSM state, including our own returning slot.
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NGROUPS; gi++) begin : g_group
         logic [CW-1:0] count_q;
         logic [CW-1:0] count_d;
         logic [CW-1:0] target_q;
         logic [CW-1:0] target_d;
         logic [CW-1:0] last_idx;
         logic          hit;

         assign hit = arrive && (arr_group == GW'(gi));
         // A zero target behaves as one participant: every arrival completes.
         assign last_idx      = (target_q == '0) ? '0 : target_q - CW'(1);
         assign complete[gi]  = hit && (count_q == last_idx);

         always_comb begin
            count_d = count_q;
            if (hit) begin
               count_d = complete[gi] ? '0 : count_q + CW'(1);
            end
         end

         // Retargeting is only safe while the group is empty and no arrival
         // for it lands in the same cycle; otherwise the write is dropped.
         always_comb begin
            target_d = target_q;
            if (bus.setTarget && (bus.targetGroup == GW'(gi)) &&
                (count_q == '0) && !hit) begin
               target_d = bus.targetIn;
            end
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               count_q  <= '0;
               target_q <= DEF_TARGET;
            end else begin
               count_q  <= count_d;
               target_q <= target_d;
            end
         end
      end
   endgenerate

   assign my_complete = complete[my_group_q];

   // -----------------------------------------------------------------------
   // Barrier request FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         my_group_q  <= '0;
         wdog_q      <= '0;
         burst_len_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.selBarrier) begin
                  my_group_q <= bus.barrierId;
                  state_q    <= S_WAIT_TOKEN;
               end
            end
            S_WAIT_TOKEN: begin
               if (token_ok) begin
                  // A non-zero train length means we must let the train
                  // pass before appending our slot at its tail.
                  if (bus.RingIn[7:0] == 8'd0) begin
                     state_q <= S_SEND;
                  end else begin
                     burst_len_q <= bus.RingIn[7:0];
                     state_q     <= S_WAIT_N;
                  end
               end
            end
            S_WAIT_N: begin
               burst_len_q <= burst_len_q - 8'd1;
               if (burst_len_q == 8'd1) begin
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               wdog_q  <= '0;
               state_q <= S_WAIT_BARRIER;
            end
            S_WAIT_BARRIER: begin
               // The arrival counter of our group is left as-is on timeout.
               if (my_complete) begin
                  state_q <= S_IDLE;
               end else if (wdog_q == TIMEOUT_W) begin
                  state_q <= S_IDLE;
               end else begin
                  wdog_q <= wdog_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Outputs. done and barrierTimeout are combinational so they line up
   // with the completing arrival / the expiring watchdog cycle.
   // -----------------------------------------------------------------------
   logic in_wait_barrier;
   logic in_send;
   logic take_token;

   assign in_wait_barrier = (state_q == S_WAIT_BARRIER);
   assign in_send         = (state_q == S_SEND);
   assign take_token      = (state_q == S_WAIT_TOKEN) && token_ok;

   assign bus.done             = bus.selBarrier && in_wait_barrier && my_complete;
   assign bus.barrierTimeout   = in_wait_barrier && !my_complete && (wdog_q == TIMEOUT_W);
   assign bus.barrierWaiting   = (state_q == S_WAIT_TOKEN);
   assign bus.barrierDriveRing = take_token || in_send || own_return;

   always_comb begin
      bus.barrierSlotTypeOut = bus.SlotTypeIn;
      bus.barrierSrcDestOut  = bus.SrcDestIn;
      bus.barrierRingOut     = bus.RingIn;
      if (in_send) begin
         bus.barrierSlotTypeOut = BARRIER_T;
         bus.barrierSrcDestOut  = bus.whichCore;
         bus.barrierRingOut     = {{(32-GW){1'b0}}, my_group_q};
      end else begin
         // Our own Barrier slot has gone all the way round: remove it.
         if (own_return) begin
            bus.barrierSlotTypeOut = NULL_T;
         end
         // Taking the Token bumps its train-length field to include us.
         if (take_token) begin
            bus.barrierRingOut = bus.RingIn + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_barrier_multi.sv
module tb_barrier_multi;

   localparam int NG  = 4;
   localparam int GW  = 2;
   localparam int CW  = 5;
   localparam int DEF = 12;
   localparam int TO  = 20;
   localparam logic [3:0] NULL_T    = 4'd7;
   localparam logic [3:0] TOKEN_T   = 4'd1;
   localparam logic [3:0] BARRIER_T = 4'd13;
   localparam logic [3:0] CORE      = 4'd2;

   localparam int PH_IDLE = 0, PH_TOKEN = 1, PH_TRAIN = 2, PH_SEND = 3, PH_WAIT = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   barrier_multi_if #(.GW(GW), .CW(CW)) bus ();

   barrier_multi #(
      .NGROUPS(NG), .GW(GW), .CW(CW), .DEFAULT_TARGET(DEF), .TIMEOUT(TO),
      .NULL_T(NULL_T), .TOKEN_T(TOKEN_T), .BARRIER_T(BARRIER_T)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_cycle = 0;

   // reference model: group bookkeeping plus where the local request is
   int m_cnt [NG];
   int m_tgt [NG];
   int m_ph;
   int m_my;
   int m_wd;
   int m_left;
   bit last_done;
   bit last_to;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, n_cycle, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < NG; g++) begin
         m_cnt[g] = 0;
         m_tgt[g] = DEF;
      end
      m_ph = PH_IDLE; m_my = 0; m_wd = 0; m_left = 0;
   endtask

   // Would an arrival for group g complete it right now?
   function automatic bit completes(input int g);
      int need;
      need = (m_tgt[g] == 0) ? 1 : m_tgt[g];
      return m_cnt[g] == need - 1;
   endfunction

   // Compare every DUT output with what the model predicts for the
   // current inputs, then advance the model by one clock.
   task automatic check_and_step();
      logic [3:0]  typ;
      logic [31:0] data;
      logic [3:0]  src;
      bit arrive, own, token, comp, my_comp;
      int ag;
      logic [31:0] e_ring;
      logic [3:0]  e_type, e_src;
      typ = bus.SlotTypeIn; data = bus.RingIn; src = bus.SrcDestIn;
      arrive  = (typ == BARRIER_T);
      ag      = int'(data[1:0]);
      own     = arrive && (src == bus.whichCore);
      token   = (typ == TOKEN_T) && !bus.msgrWaiting && !bus.lockerWaiting;
      comp    = arrive && completes(ag);
      my_comp = comp && (ag == m_my);

      e_type = typ; e_src = src; e_ring = data;
      if (m_ph == PH_SEND) begin
         e_type = BARRIER_T; e_src = bus.whichCore; e_ring = 32'(m_my);
      end else begin
         if (own) e_type = NULL_T;
         if (m_ph == PH_TOKEN && token) e_ring = data + 32'd1;
      end
      last_done = bus.selBarrier && (m_ph == PH_WAIT) && my_comp;
      last_to   = (m_ph == PH_WAIT) && !my_comp && (m_wd == TO);

      check_val("done",     32'(bus.done),             32'(last_done));
      check_val("timeout",  32'(bus.barrierTimeout),   32'(last_to));
      check_val("waiting",  32'(bus.barrierWaiting),   32'(m_ph == PH_TOKEN));
      check_val("drive",    32'(bus.barrierDriveRing),
                32'((m_ph == PH_TOKEN && token) || m_ph == PH_SEND || own));
      check_val("ring_out", bus.barrierRingOut,        e_ring);
      check_val("type_out", 32'(bus.barrierSlotTypeOut), 32'(e_type));
      check_val("src_out",  32'(bus.barrierSrcDestOut),  32'(e_src));

      // target write uses pre-arrival occupancy
      if (bus.setTarget && m_cnt[bus.targetGroup] == 0 && !(arrive && ag == int'(bus.targetGroup)))
         m_tgt[bus.targetGroup] = int'(bus.targetIn);
      if (arrive) m_cnt[ag] = comp ? 0 : (m_cnt[ag] + 1) % (1 << CW);

      case (m_ph)
         PH_IDLE:  if (bus.selBarrier) begin m_my = int'(bus.barrierId); m_ph = PH_TOKEN; end
         PH_TOKEN: if (token) begin
                      m_left = int'(data[7:0]);
                      m_ph = (m_left == 0) ? PH_SEND : PH_TRAIN;
                   end
         PH_TRAIN: begin m_left--; if (m_left == 0) m_ph = PH_SEND; end
         PH_SEND:  begin m_wd = 0; m_ph = PH_WAIT; end
         PH_WAIT:  if (my_comp || m_wd == TO) m_ph = PH_IDLE; else m_wd++;
         default:  m_ph = PH_IDLE;
      endcase
   endtask

   // One ring cycle: present a slot, check, clock. The core drops its
   // request once the barrier is done or has timed out.
   task automatic ring_cycle(input logic [3:0] typ, input logic [31:0] data, input logic [3:0] src);
      bus.SlotTypeIn = typ; bus.RingIn = data; bus.SrcDestIn = src;
      #2;
      check_and_step();
      @(posedge clock); #1;
      n_cycle++;
      bus.setTarget = 1'b0;
      if (last_done) $display("[TB] cycle %0d: barrier done for group %0d", n_cycle, m_my);
      if (last_to)   $display("[TB] cycle %0d: barrier timeout for group %0d", n_cycle, m_my);
      if (last_done || last_to) bus.selBarrier = 1'b0;
   endtask

   task automatic null_cycles(input int n);
      for (int i = 0; i < n; i++) ring_cycle(NULL_T, $urandom(), 4'($urandom_range(0, 15)));
   endtask

   task automatic arrival(input int g, input logic [3:0] src);
      ring_cycle(BARRIER_T, ($urandom() & 32'hFFFF_FFFC) | 32'(g), src);
   endtask

   task automatic set_target(input int g, input int t);
      bus.setTarget = 1'b1; bus.targetGroup = GW'(g); bus.targetIn = CW'(t);
   endtask

   task automatic request(input int g);
      bus.selBarrier = 1'b1; bus.barrierId = GW'(g);
      null_cycles(1);
   endtask

   initial begin
      bus.selBarrier = 0; bus.barrierId = 0; bus.setTarget = 0; bus.targetGroup = 0;
      bus.targetIn = 0; bus.whichCore = CORE; bus.msgrWaiting = 0; bus.lockerWaiting = 0;
      bus.RingIn = 32'h1234_5678; bus.SlotTypeIn = NULL_T; bus.SrcDestIn = 4'd9;
      model_reset();

      // reset state
      #3;
      check_val("rst_done",    32'(bus.done),             32'd0);
      check_val("rst_timeout", 32'(bus.barrierTimeout),   32'd0);
      check_val("rst_drive",   32'(bus.barrierDriveRing), 32'd0);
      check_val("rst_waiting", 32'(bus.barrierWaiting),   32'd0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;

      // g1 target 3, token with empty train, two foreign + own arrival
      set_target(1, 3);
      null_cycles(1);
      request(1);
      ring_cycle(TOKEN_T, 32'h0000_0000, 4'd0);
      null_cycles(1);                      // send slot
      arrival(1, 4'd5);
      arrival(1, 4'd6);
      arrival(1, CORE);                    // completes, own slot nulled
      null_cycles(2);

      // contended token ignored, then token with a 3-slot train
      set_target(1, 2);
      null_cycles(1);
      request(1);
      bus.msgrWaiting = 1'b1;
      ring_cycle(TOKEN_T, 32'h0000_0003, 4'd1);
      bus.msgrWaiting = 1'b0;
      ring_cycle(TOKEN_T, 32'h0000_0003, 4'd1);
      null_cycles(3);                      // train passes
      null_cycles(1);                      // send slot
      arrival(0, 4'd7);                    // interleaved g0 arrivals
      arrival(1, CORE);
      arrival(0, 4'd8);
      arrival(1, 4'd4);                    // g1 complete after 2
      null_cycles(1);

      // watchdog: only our own arrival after send
      request(3);
      ring_cycle(TOKEN_T, 32'h0000_0000, 4'd0);
      null_cycles(1);
      arrival(3, CORE);
      null_cycles(TO + 3);

      // retarget while occupied is dropped; after wrap a zero target sticks
      arrival(2, 4'd9);
      set_target(2, 0);
      null_cycles(1);
      for (int i = 0; i < DEF - 1; i++) arrival(2, 4'd10);
      set_target(2, 0);
      null_cycles(1);
      request(2);
      ring_cycle(TOKEN_T, 32'h0000_0000, 4'd0);
      null_cycles(1);
      arrival(2, CORE);                    // single arrival completes
      null_cycles(1);

      // reset in the middle of a train wait
      set_target(1, 4);
      null_cycles(1);
      request(1);
      ring_cycle(TOKEN_T, 32'h0000_0005, 4'd0);
      null_cycles(2);
      reset = 1'b0;
      bus.SlotTypeIn = NULL_T;
      model_reset();
      #1;
      check_val("mid_rst_waiting", 32'(bus.barrierWaiting),   32'd0);
      check_val("mid_rst_drive",   32'(bus.barrierDriveRing), 32'd0);
      check_val("mid_rst_done",    32'(bus.done),             32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      bus.selBarrier = 1'b0;
      null_cycles(1);
      request(1);                          // target back to 12
      ring_cycle(TOKEN_T, 32'h0000_0000, 4'd0);
      null_cycles(1);
      for (int i = 0; i < DEF - 1; i++) arrival(1, 4'd11);
      arrival(1, CORE);
      null_cycles(1);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [3:0]  typ;
         logic [31:0] data;
         if (m_ph == PH_IDLE && !bus.selBarrier && $urandom_range(0, 3) == 0) begin
            bus.selBarrier = 1'b1; bus.barrierId = GW'($urandom_range(0, NG - 1));
         end else if (bus.selBarrier && $urandom_range(0, 60) == 0) begin
            bus.selBarrier = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) set_target($urandom_range(0, NG - 1), $urandom_range(0, 4));
         bus.msgrWaiting   = ($urandom_range(0, 5) == 0);
         bus.lockerWaiting = ($urandom_range(0, 5) == 0);
         r = $urandom_range(0, 9);
         data = $urandom();
         if (r < 4)      typ = NULL_T;
         else if (r < 6) begin typ = TOKEN_T; data[7:0] = 8'($urandom_range(0, 3)); end
         else if (r < 9) typ = BARRIER_T;
         else            typ = 4'd3;
         ring_cycle(typ, data, ($urandom_range(0, 2) == 0) ? CORE : 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
